// File: rtl/lns_pkg.sv
// Shared LNS definitions: default log-field width, z saturation floor and
// the operand record (sign, exact-zero flag, signed Q3.8 log magnitude).
package lns_pkg;

  localparam int LOG_W = 11;
  localparam int Z_MIN = -1024;

  typedef struct packed {
    logic             sign;
    logic             zero;
    logic [LOG_W-1:0] log;
  } lns_t;

endpackage

// File: rtl/lns_skid_buf.sv
// Two-entry skid buffer with a registered ready. The main register always
// drives the output; the skid register catches the one word that can arrive
// in the cycle the consumer stalls. in_ready depends only on local state.
module lns_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_fire;
  logic         main_free;

  // Refill the main register from the skid entry first, then from the input.
  always_comb begin
    in_fire      = in_valid && !skid_valid_q;
    main_free    = !main_valid_q || out_ready;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (main_free) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = in_fire;
        main_d       = in_data;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_d       = in_data;
    end
  end

  // Occupancy bits clear on reset; payload registers are left free-running.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Payload capture.
  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/lns_operand_align.sv
// LNS adder front end: orders an operand pair by log magnitude and produces
// the saturated non-positive difference z for the s_b lookup, plus the
// special-case flags. Optional build macro LNS_ALIGN_SKID_EN inserts a
// registered-ready skid buffer ahead of the two compute stages.
module lns_operand_align #(
  parameter int LOG_W = lns_pkg::LOG_W,
  parameter int Z_MIN = lns_pkg::Z_MIN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a_sign,
  input  logic             b_sign,
  input  logic             a_zero,
  input  logic             b_zero,
  input  logic [LOG_W-1:0] a_log,
  input  logic [LOG_W-1:0] b_log,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOG_W-1:0] z,
  output logic [LOG_W-1:0] max_log,
  output logic             res_sign,
  output logic             eff_sub,
  output logic             bypass,
  output logic             cancel,
  output logic             zero_out
);
  import lns_pkg::*;

  localparam int               PW      = 2 * (LOG_W + 2);
  localparam logic [LOG_W:0]   SAT_MAG = (LOG_W+1)'(-Z_MIN);
  localparam logic [LOG_W-1:0] Z_SAT   = LOG_W'(Z_MIN);
  localparam logic [LOG_W-1:0] ONE     = LOG_W'(1);

  logic [PW-1:0] in_pay, s0_pay;
  logic          s0_valid, s0_ready;

  assign in_pay = {a_sign, a_zero, a_log, b_sign, b_zero, b_log};

`ifdef LNS_ALIGN_SKID_EN
  lns_skid_buf #(.W(PW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pay),
    .out_valid (s0_valid),
    .out_ready (s0_ready),
    .out_data  (s0_pay)
  );
`else
  assign s0_valid = in_valid;
  assign s0_pay   = in_pay;
  assign in_ready = s0_ready;
`endif

  logic             u_a_sign, u_a_zero, u_b_sign, u_b_zero;
  logic [LOG_W-1:0] u_a_log, u_b_log;

  assign u_a_sign = s0_pay[PW-1];
  assign u_a_zero = s0_pay[PW-2];
  assign u_a_log  = s0_pay[PW-3 -: LOG_W];
  assign u_b_sign = s0_pay[LOG_W+1];
  assign u_b_zero = s0_pay[LOG_W];
  assign u_b_log  = s0_pay[LOG_W-1:0];

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [LOG_W:0]   d_q, d_d;
  logic [LOG_W-1:0] s1_max_log_q, s1_max_log_d;
  logic             s1_max_sign_q, s1_max_sign_d;
  logic             s1_sign_diff_q, s1_sign_diff_d;
  logic             s1_a_zero_q, s1_a_zero_d;
  logic             s1_b_zero_q, s1_b_zero_d;

  // Stage 2 state
  logic             s2_valid_q, s2_valid_d;
  logic [LOG_W-1:0] z_q, z_d;
  logic [LOG_W-1:0] max_log_q, max_log_d;
  logic             res_sign_q, res_sign_d;
  logic             eff_sub_q, eff_sub_d;
  logic             bypass_q, bypass_d;
  logic             cancel_q, cancel_d;
  logic             zero_out_q, zero_out_d;

  logic             s1_fire, s2_adv;
  logic [LOG_W:0]   abs_d;
  logic [LOG_W-1:0] z_norm;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s0_ready = !s1_valid_q || s2_adv;
  assign s1_fire  = s0_valid && s0_ready;

  // Stage 1: widened difference and larger-operand pick; a nonzero operand
  // always beats an exact zero, otherwise a wins ties.
  always_comb begin
    s1_valid_d     = s1_valid_q;
    d_d            = d_q;
    s1_max_log_d   = s1_max_log_q;
    s1_max_sign_d  = s1_max_sign_q;
    s1_sign_diff_d = s1_sign_diff_q;
    s1_a_zero_d    = s1_a_zero_q;
    s1_b_zero_d    = s1_b_zero_q;
    if (s1_fire) begin
      s1_valid_d     = 1'b1;
      d_d            = {u_a_log[LOG_W-1], u_a_log} - {u_b_log[LOG_W-1], u_b_log};
      s1_sign_diff_d = u_a_sign ^ u_b_sign;
      s1_a_zero_d    = u_a_zero;
      s1_b_zero_d    = u_b_zero;
      if (u_a_zero || (!u_b_zero && d_d[LOG_W])) begin
        s1_max_log_d  = u_b_log;
        s1_max_sign_d = u_b_sign;
      end else begin
        s1_max_log_d  = u_a_log;
        s1_max_sign_d = u_a_sign;
      end
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2: z = -|d| with floor saturation, then special-case overrides.
  always_comb begin
    abs_d      = d_q[LOG_W] ? (~d_q + (LOG_W+1)'(1)) : d_q;
    z_norm     = ~abs_d[LOG_W-1:0] + ONE;
    s2_valid_d = s2_valid_q;
    z_d        = z_q;
    max_log_d  = max_log_q;
    res_sign_d = res_sign_q;
    eff_sub_d  = eff_sub_q;
    bypass_d   = bypass_q;
    cancel_d   = cancel_q;
    zero_out_d = zero_out_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      z_d        = (abs_d > SAT_MAG) ? Z_SAT : z_norm;
      max_log_d  = s1_max_log_q;
      res_sign_d = s1_max_sign_q;
      eff_sub_d  = s1_sign_diff_q;
      bypass_d   = 1'b0;
      cancel_d   = 1'b0;
      zero_out_d = 1'b0;
      if (s1_a_zero_q && s1_b_zero_q) begin
        bypass_d   = 1'b1;
        zero_out_d = 1'b1;
        max_log_d  = '0;
        res_sign_d = 1'b0;
        z_d        = Z_SAT;
        eff_sub_d  = 1'b0;
      end else if (s1_a_zero_q || s1_b_zero_q) begin
        bypass_d  = 1'b1;
        z_d       = Z_SAT;
        eff_sub_d = 1'b0;
      end else if (s1_sign_diff_q && (d_q == '0)) begin
        cancel_d   = 1'b1;
        zero_out_d = 1'b1;
        res_sign_d = 1'b0;
        z_d        = '0;
      end
    end
  end

  // Stage valid bits are the only reset state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // Pipeline data registers, held by their own enables.
  always_ff @(posedge clk) begin
    d_q            <= d_d;
    s1_max_log_q   <= s1_max_log_d;
    s1_max_sign_q  <= s1_max_sign_d;
    s1_sign_diff_q <= s1_sign_diff_d;
    s1_a_zero_q    <= s1_a_zero_d;
    s1_b_zero_q    <= s1_b_zero_d;
    z_q            <= z_d;
    max_log_q      <= max_log_d;
    res_sign_q     <= res_sign_d;
    eff_sub_q      <= eff_sub_d;
    bypass_q       <= bypass_d;
    cancel_q       <= cancel_d;
    zero_out_q     <= zero_out_d;
  end

  assign out_valid = s2_valid_q;
  assign z         = z_q;
  assign max_log   = max_log_q;
  assign res_sign  = res_sign_q;
  assign eff_sub   = eff_sub_q;
  assign bypass    = bypass_q;
  assign cancel    = cancel_q;
  assign zero_out  = zero_out_q;

endmodule

// File: tb/tb_lns_operand_align.sv
// Self-checking bench for lns_operand_align: directed corner pairs, a stalled
// back-to-back stream, randomized traffic and a mid-stream reset, all scored
// against an arithmetic reference model. Honours LNS_ALIGN_SKID_EN.
module tb_lns_operand_align;
  import lns_pkg::*;

  localparam int W = LOG_W;
`ifdef LNS_ALIGN_SKID_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready;
  logic         a_sign, b_sign, a_zero, b_zero;
  logic [W-1:0] a_log, b_log;
  logic         out_valid, out_ready;
  logic [W-1:0] z, max_log;
  logic         res_sign, eff_sub, bypass, cancel, zero_out;

  always #5 clk = ~clk;

  lns_operand_align dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_sign    (a_sign),
    .b_sign    (b_sign),
    .a_zero    (a_zero),
    .b_zero    (b_zero),
    .a_log     (a_log),
    .b_log     (b_log),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .max_log   (max_log),
    .res_sign  (res_sign),
    .eff_sub   (eff_sub),
    .bypass    (bypass),
    .cancel    (cancel),
    .zero_out  (zero_out)
  );

  typedef struct {
    logic [W-1:0] z;
    logic [W-1:0] max_log;
    logic         res_sign;
    logic         eff_sub;
    logic         bypass;
    logic         cancel;
    logic         zero_out;
    int           t_in;
  } exp_t;

  exp_t           exp_q[$];
  int             checks = 0;
  int             failures = 0;
  int             cycle = 0;
  bit             accepted = 0;
  bit             check_lat = 0;
  bit             held = 0;
  lns_t           cur_a, cur_b;
  logic [2*W+4:0] held_val;
  logic [2*W+4:0] obs_vec;

  assign obs_vec = {z, max_log, res_sign, eff_sub, bypass, cancel, zero_out};

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cycle);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input lns_t a, input lns_t b);
    exp_t e;
    int   al, bl, d, mag, zi;
    al = int'($signed(a.log));
    bl = int'($signed(b.log));
    d  = al - bl;
    e.bypass = 0; e.cancel = 0; e.zero_out = 0; e.eff_sub = 0; e.t_in = 0;
    e.res_sign = 0; e.max_log = '0;
    zi = Z_MIN;
    if (a.zero && b.zero) begin
      e.bypass = 1; e.zero_out = 1;
    end else if (a.zero) begin
      e.bypass = 1; e.max_log = b.log; e.res_sign = b.sign;
    end else if (b.zero) begin
      e.bypass = 1; e.max_log = a.log; e.res_sign = a.sign;
    end else begin
      e.eff_sub = (a.sign != b.sign);
      if (e.eff_sub && d == 0) begin
        e.cancel = 1; e.zero_out = 1; e.max_log = a.log; zi = 0;
      end else begin
        if (d >= 0) begin e.max_log = a.log; e.res_sign = a.sign; end
        else begin e.max_log = b.log; e.res_sign = b.sign; end
        mag = (d < 0) ? -d : d;
        zi  = (mag > -Z_MIN) ? Z_MIN : -mag;
      end
    end
    e.z = zi[W-1:0];
    return e;
  endfunction

  function automatic lns_t mk(input logic s, input logic zr, input int lg);
    lns_t r;
    r.sign = s; r.zero = zr; r.log = lg[W-1:0];
    return r;
  endfunction

  function automatic lns_t randOp();
    lns_t r;
    int   sel;
    r.sign = 1'($urandom_range(1, 0));
    r.zero = ($urandom_range(7, 0) == 0);
    sel    = $urandom_range(5, 0);
    if (sel == 0)      r.log = {1'b0, {(W-1){1'b1}}};
    else if (sel == 1) r.log = {1'b1, {(W-1){1'b0}}};
    else               r.log = W'($urandom);
    return r;
  endfunction

  task automatic applyStimulus(input lns_t a, input lns_t b, input logic v);
    cur_a    = a;
    cur_b    = b;
    a_sign   = a.sign; a_zero = a.zero; a_log = a.log;
    b_sign   = b.sign; b_zero = b.zero; b_log = b.log;
    in_valid = v;
  endtask

  task automatic newRandomPair(input logic v);
    lns_t a, b;
    a = randOp();
    b = randOp();
    if ($urandom_range(4, 0) == 0) b.log = a.log;
    applyStimulus(a, b, v);
  endtask

  // One clock: score handshakes at the falling edge, then step past the rising edge.
  task automatic tick();
    exp_t e;
    accepted = 0;
    @(negedge clk);
    if (rst_n) begin
      if (held) begin
        checkOutput("stall_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_stable", 32'(obs_vec), 32'(held_val));
      end
      held = 0;
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checkOutput("spurious_out", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("z", 32'(z), 32'(e.z));
            if (!e.cancel) checkOutput("max_log", 32'(max_log), 32'(e.max_log));
            checkOutput("res_sign", 32'(res_sign), 32'(e.res_sign));
            checkOutput("eff_sub", 32'(eff_sub), 32'(e.eff_sub));
            checkOutput("flags", 32'({bypass, cancel, zero_out}),
                        32'({e.bypass, e.cancel, e.zero_out}));
            if (check_lat) checkOutput("latency", 32'(cycle - e.t_in), 32'(LAT));
          end
        end else begin
          held     = 1;
          held_val = obs_vec;
        end
      end
      if (in_valid && in_ready) begin
        e      = model(cur_a, cur_b);
        e.t_in = cycle;
        exp_q.push_back(e);
        accepted = 1;
      end
    end else begin
      held = 0;
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  function automatic logic patReady(input int c);
    return (c % 4 == 0) || (c % 4 == 3);
  endfunction

  // mode 0: ready always high, 1: 1,0,0,1 pattern, 2: random.
  task automatic drain(input int mode);
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) begin
      if (mode == 0)      out_ready = 1'b1;
      else if (mode == 1) out_ready = patReady(cycle);
      else                out_ready = ($urandom_range(2, 0) != 0);
      tick();
    end
    checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic runOne(input lns_t a, input lns_t b);
    applyStimulus(a, b, 1'b1);
    tick();
    checkOutput("dir_accept", 32'(accepted), 32'd1);
    in_valid = 1'b0;
    drain(0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int sent;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(mk(0, 0, 0), mk(0, 0, 0), 1'b0);
    repeat (3) tick();
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] directed pairs");
    check_lat = 1;
    runOne(mk(0, 0, 'h100), mk(0, 0, 'h080));
    runOne(mk(0, 0, 'h3FF), mk(1, 0, 'h400));
    runOne(mk(1, 0, 'h050), mk(0, 0, 'h050));
    runOne(mk(0, 1, 'h123), mk(1, 0, 'h020));
    runOne(mk(1, 0, 'h555), mk(0, 1, 'h000));
    runOne(mk(1, 1, 'h0AA), mk(0, 1, 'h3C0));
    runOne(mk(0, 0, 'h080), mk(1, 0, 'h100));
    runOne(mk(1, 0, 'h7F0), mk(1, 0, 'h7F0));
    runOne(mk(0, 0, 'h400), mk(0, 0, 'h000));
    runOne(mk(0, 0, 'h3FF), mk(0, 0, 'h7FF));
    check_lat = 0;

    $display("[TB] stalled 8-pair stream");
    sent = 0;
    newRandomPair(1'b1);
    for (int i = 0; i < 200 && sent < 8; i++) begin
      out_ready = patReady(cycle);
      tick();
      if (accepted) begin
        sent++;
        if (sent < 8) newRandomPair(1'b1);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checkOutput("stream_sent", 32'(sent), 32'd8);
    drain(1);

    $display("[TB] random traffic");
    newRandomPair(1'b0);
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || accepted) newRandomPair(($urandom_range(3, 0) != 0));
      out_ready = ($urandom_range(2, 0) != 0);
      tick();
    end
    if (in_valid && !accepted) begin
      for (int i = 0; i < 20 && !accepted; i++) tick();
    end
    in_valid = 1'b0;
    drain(2);

    $display("[TB] reset with pairs in flight");
    out_ready = 1'b0;
    sent = 0;
    newRandomPair(1'b1);
    for (int i = 0; i < 20 && sent < 2; i++) begin
      tick();
      if (accepted) begin
        sent++;
        if (sent < 2) newRandomPair(1'b1);
      end
    end
    in_valid = 1'b0;
    checkOutput("inflight_sent", 32'(sent), 32'd2);
    rst_n = 1'b0;
    tick();
    exp_q.delete();
    held  = 0;
    rst_n = 1'b1;
    #1;
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checkOutput("post_reset_quiet", 32'(out_valid), 32'd0);
      tick();
    end

    $display("[TB] post-reset sanity pair");
    runOne(mk(0, 0, 'h200), mk(1, 0, 'h1F0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lns_operand_align.md
LNS_OPERAND_ALIGN -- requirements
Module: lns_operand_align

Interface
REQ-001 Parameter LOG_W, default 11, width of the signed Q3.8 log-magnitude field.
REQ-002 Parameter Z_MIN, default -1024, saturation floor for z.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 in_valid  in  1  operand pair valid.
REQ-006 in_ready  out  1  block accepts the pair this cycle.
REQ-007 a_sign, b_sign  in  1 each  operand sign (1 = negative).
REQ-008 a_zero, b_zero  in  1 each  operand is exact zero; its log field is don't-care.
REQ-009 a_log, b_log  in  LOG_W each  signed log2 magnitude, Q3.8.
REQ-010 out_valid  out  1  result valid.
REQ-011 out_ready  in  1  downstream (s_b / final adder) accepts.
REQ-012 z  out  LOG_W  signed min_log - max_log, always <= 0, saturated; feeds the s_b approximation.
REQ-013 max_log  out  LOG_W  larger log magnitude.
REQ-014 res_sign  out  1  sign of the larger-magnitude operand.
REQ-015 eff_sub  out  1  operand signs differ.
REQ-016 bypass, cancel, zero_out  out  1 each  special-case flags (REQ-023..026).

Function
REQ-017 Transfer on a port occurs only when valid and ready are both high in the same cycle.
REQ-018 Two-stage pipeline: stage 1 registers d = a_log - b_log (LOG_W+1 bits, sign-extended), the comparison result and flags; stage 2 registers the saturated z, max_log and final flags.
REQ-019 Latency from input transfer to out_valid is exactly 2 cycles when out_ready stays high; throughput is 1 pair/cycle.
REQ-020 A stage advances when its successor is empty or is transferring in the same cycle; out_valid, once high, holds all outputs stable until the transfer.
REQ-021 The operand with d >= 0 is max (a wins ties): max_log = max operand's log, res_sign = its sign, and z = -|d|.
REQ-022 If |d| > -Z_MIN, then z = Z_MIN (no wrap).
REQ-023 Exactly one zero operand: bypass = 1, max_log/res_sign taken from the nonzero operand, z = Z_MIN, eff_sub = 0.
REQ-024 Both operands zero: zero_out = 1, bypass = 1, max_log = 0, res_sign = 0, z = Z_MIN.
REQ-025 eff_sub = 1 and d = 0: cancel = 1, zero_out = 1, res_sign = 0, z = 0.
REQ-026 All flags are 0 for ordinary pairs; bypass, cancel and zero_out are never asserted for any other combination.
REQ-027 Without skid (REQ-031), in_ready = !stage1_valid || stage1_advances, combinational.

Reset
REQ-028 While rst_n is low at a clock edge, both stage-valid bits clear; out_valid = 0 the following cycle.
REQ-029 Data registers are not reset; while out_valid = 0, z, max_log and the flags are don't-care.
REQ-030 Reset asserted mid-stream discards all in-flight pairs; in_ready = 1 in the first cycle after reset is released.

Configuration
REQ-031 LNS_ALIGN_SKID_EN defined: a 2-entry input skid buffer makes in_ready a register output, with no combinational path from out_ready to in_ready; latency becomes 3 cycles and throughput stays at 1/cycle.
REQ-032 LNS_ALIGN_SKID_EN undefined: no skid buffer; REQ-019 and REQ-027 apply.

Structure
REQ-033 A shared package lns_pkg holds LOG_W, Z_MIN and the lns_t struct (sign, zero, log).
REQ-034 The skid buffer is a sub-module, lns_skid_buf, parameterised on payload width and reused by downstream stages.

Verification
REQ-035 a = (+, 0x100), b = (+, 0x080), out_ready = 1 -> after 2 cycles: z = -128, max_log = 0x100, res_sign = 0, all flags 0.
REQ-036 a = (+, 0x3FF), b = (-, 0x400) -> z = Z_MIN (|d| = 2047 saturates), max_log = 0x3FF, eff_sub = 1.
REQ-037 a = (-, 0x050), b = (+, 0x050) -> cancel = 1, zero_out = 1, res_sign = 0, z = 0.
REQ-038 a_zero = 1, b = (-, 0x020) -> bypass = 1, max_log = 0x020, res_sign = 1, z = Z_MIN; both zero -> zero_out = 1.
REQ-039 Back-to-back stream of 8 pairs with out_ready toggling 1,0,0,1 repeating -> no pair lost or duplicated, outputs stable while stalled, in-order output; repeat with LNS_ALIGN_SKID_EN defined.
REQ-040 rst_n pulled low for one cycle with 2 pairs in flight -> out_valid = 0 on the next cycle, neither pair emerges, in_ready = 1 after release.
